// File: rtl/tdm_pkg.sv
// Shared definitions for the 8-slot TDM link (transmitter and receiver).
package tdm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } tdm_state_t;

  localparam int TDM_SLOTS = 8;
  localparam int TDM_SEL_W = 3;

endpackage

// File: rtl/tdm_slot_bank.sv
// Shadow register array: one WIDTH-bit word per TDM slot, written by index.
module tdm_slot_bank
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         we,
  input  logic [TDM_SEL_W-1:0]         widx,
  input  logic [WIDTH-1:0]             wdata,
  output logic [TDM_SLOTS*WIDTH-1:0]   bank
);

  logic [WIDTH-1:0] mem [TDM_SLOTS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TDM_SLOTS; k++) mem[k] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

  always_comb begin
    bank = '0;
    for (int k = 0; k < TDM_SLOTS; k++) bank[k*WIDTH +: WIDTH] = mem[k];
  end

endmodule

// File: rtl/tdm_demux8.sv
// TDM receiver: collects eight slot words after a sync-marked slot 0 and
// presents them as one registered frame with a single-cycle valid strobe.
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH-1:0]            din,
  input  logic                        din_valid,
  input  logic                        din_sync,
  output logic [TDM_SLOTS*WIDTH-1:0]  dout,
  output logic                        dout_valid,
  output logic [TDM_SEL_W-1:0]        slot,
  output logic                        busy,
  output logic                        frame_err
);

  localparam int FW = TDM_SLOTS * WIDTH;
  localparam logic [TDM_SEL_W-1:0] LAST_SLOT = TDM_SEL_W'(TDM_SLOTS - 1);

  tdm_state_t            state, state_n;
  logic [TDM_SEL_W-1:0]  slot_q, slot_n;
  logic [TDM_SEL_W-1:0]  widx;
  logic                  we;
  logic                  load;
  logic                  vld_n;
  logic                  err_n;
  logic [FW-1:0]         bank;
  logic [FW-1:0]         frame;

  logic [FW-1:0]         dout_p0;
  logic                  vld_p0;
  logic                  err_p0;

  tdm_slot_bank #(
    .WIDTH (WIDTH)
  ) u_bank (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .widx  (widx),
    .wdata (din),
    .bank  (bank)
  );

  // The last slot bypasses the shadow so the frame loads on the beat that completes it.
  always_comb begin
    frame = bank;
    frame[FW-1 -: WIDTH] = din;
  end

  always_comb begin
    state_n = state;
    slot_n  = slot_q;
    we      = 1'b0;
    widx    = slot_q;
    load    = 1'b0;
    vld_n   = 1'b0;
    err_n   = 1'b0;
    if (din_valid) begin
      if (din_sync) begin
        // A sync always restarts at slot 0; inside a frame it aborts the partial one.
        we      = 1'b1;
        widx    = '0;
        slot_n  = TDM_SEL_W'(1);
        state_n = RECV;
        err_n   = (state == RECV);
      end else if (state == RECV) begin
        we = 1'b1;
        if (slot_q == LAST_SLOT) begin
          load    = 1'b1;
          vld_n   = 1'b1;
          slot_n  = '0;
          state_n = IDLE;
        end else begin
          slot_n = slot_q + TDM_SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      slot_q <= '0;
      vld_p0 <= 1'b0;
      err_p0 <= 1'b0;
    end else begin
      state  <= state_n;
      slot_q <= slot_n;
      vld_p0 <= vld_n;
      err_p0 <= err_n;
    end
  end

  // Output frame register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_p0 <= '0;
    end else if (load) begin
      dout_p0 <= frame;
    end
  end

  assign dout       = dout_p0;
  assign dout_valid = vld_p0;
  assign frame_err  = err_p0;
  assign slot       = slot_q;
  assign busy       = (state == RECV);

endmodule

// File: tb/tb_tdm_demux8.sv
// Randomized and directed bench for tdm_demux8 against a queue-based frame model.
module tb_tdm_demux8;

  logic       clk = 1'b0;
  logic       rst;
  logic [0:0] din;
  logic       din_valid;
  logic       din_sync;
  logic [7:0] dout;
  logic       dout_valid;
  logic [2:0] slot;
  logic       busy;
  logic       frame_err;

  tdm_demux8 #(.WIDTH(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_sync   (din_sync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .slot       (slot),
    .busy       (busy),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: words of the current frame held in a queue.
  bit        m_inframe;
  bit        m_words[$];
  logic [7:0] m_dout;
  bit        m_vld;
  bit        m_err;

  int cyc = 0;
  int n_strobe = 0;
  int n_ferr = 0;
  int last_strobe_cyc = 0;
  int prev_strobe_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit s, input bit d);
    if (r) begin
      m_inframe = 0;
      m_words.delete();
      m_dout = 8'h00;
      m_vld = 0;
      m_err = 0;
    end else begin
      m_vld = 0;
      m_err = 0;
      if (v) begin
        if (s) begin
          if (m_inframe) m_err = 1;
          m_words.delete();
          m_words.push_back(d);
          m_inframe = 1;
        end else if (m_inframe) begin
          m_words.push_back(d);
          if (m_words.size() == 8) begin
            for (int k = 0; k < 8; k++) m_dout[k] = m_words[k];
            m_vld = 1;
            m_words.delete();
            m_inframe = 0;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit v, input bit s, input bit d);
    @(negedge clk);
    rst = r; din_valid = v; din_sync = s; din = d;
    @(posedge clk);
    model_step(r, v, s, d);
    #1;
    cyc++;
    if (dout_valid === 1'b1) begin
      n_strobe++;
      prev_strobe_cyc = last_strobe_cyc;
      last_strobe_cyc = cyc;
    end
    if (frame_err === 1'b1) n_ferr++;
    chk("dout", 32'(dout), 32'(m_dout));
    chk("dout_valid", 32'(dout_valid), 32'(m_vld));
    chk("frame_err", 32'(frame_err), 32'(m_err));
    chk("busy", 32'(busy), 32'(m_inframe));
    chk("slot", 32'(slot), 32'(m_words.size()));
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic send_frame(input logic [7:0] b, input int maxgap);
    for (int k = 0; k < 8; k++) begin
      if (k > 0 && maxgap > 0) idle_gap($urandom_range(0, maxgap));
      drive(1'b0, 1'b1, (k == 0), b[k]);
    end
  endtask

  int s0, e0;

  initial begin
    rst = 1'b1; din_valid = 1'b0; din_sync = 1'b0; din = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_dout", 32'(dout), 32'h0);
    chk("reset_slot", 32'(slot), 32'h0);

    // 1: plain frame 0,1,1,0,1,0,0,1
    s0 = n_strobe;
    send_frame(8'b1001_0110, 0);
    chk("t1_dout", 32'(dout), 32'h96);
    chk("t1_vld", 32'(dout_valid), 32'h1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_vld_drop", 32'(dout_valid), 32'h0);
    chk("t1_strobes", 32'(n_strobe - s0), 32'd1);

    // 2: frame with idle gaps
    s0 = n_strobe;
    send_frame(8'b1000_1110, 3);
    chk("t2_dout", 32'(dout), 32'h8E);
    idle_gap(2);
    chk("t2_strobes", 32'(n_strobe - s0), 32'd1);

    // 3: early sync at slot 5
    s0 = n_strobe; e0 = n_ferr;
    send_frame(8'h00, 0);
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, (k == 0), 1'b1);
    chk("t3_slot5", 32'(slot), 32'd5);
    drive(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t3_err", 32'(frame_err), 32'h1);
    chk("t3_dout_kept", 32'(dout), 32'h00);
    for (int k = 1; k < 8; k++) drive(1'b0, 1'b1, 1'b0, k[0]);
    chk("t3_dout_new", 32'(dout), 32'hAB);
    chk("t3_ferr_count", 32'(n_ferr - e0), 32'd1);

    // 4: non-sync beats while idle are dropped
    s0 = n_strobe;
    for (int k = 0; k < 6; k++) drive(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)));
    chk("t4_slot", 32'(slot), 32'd0);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_strobes", 32'(n_strobe - s0), 32'd0);

    // 5: back-to-back frames
    s0 = n_strobe;
    send_frame(8'hA5, 0);
    chk("t5_dout_a", 32'(dout), 32'hA5);
    send_frame(8'h3C, 0);
    chk("t5_dout_b", 32'(dout), 32'h3C);
    chk("t5_strobes", 32'(n_strobe - s0), 32'd2);
    chk("t5_spacing", 32'(last_strobe_cyc - prev_strobe_cyc), 32'd8);

    // 6: reset after slot 4
    s0 = n_strobe;
    for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, (k == 0), 1'b1);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_dout", 32'(dout), 32'h0);
    chk("t6_busy", 32'(busy), 32'h0);
    chk("t6_slot", 32'(slot), 32'h0);
    chk("t6_strobes", 32'(n_strobe - s0), 32'd0);
    send_frame(8'h5E, 1);
    chk("t6_dout_after", 32'(dout), 32'h5E);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) < 6),
            ($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 1)));
    end
    for (int f = 0; f < 20; f++) send_frame(8'($urandom), $urandom_range(0, 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
